udp_decode: RTL and testbench
=============================

// Module: udp_decode
// PURPOSE
//   Byte-serial UDP header parser; sits directly downstream of ip_decode in the RX path.
//   - Starts on the first byte after the IPv4 header.
//   - Extracts source port, destination port and length.
//   - Filters on destination port and streams the payload bytes out with valid/last.
//   - Reports done/err per datagram.
// PARAMETERS
//   LISTEN_PORT  16'd5000  destination port accepted; any other port -> err, no payload out
//   MAX_PAYLOAD  16'd1472  largest accepted payload (udp_len-8); larger -> err
// PORTS
//   clk         in   1   system clock
//   rst         in   1   reset
//   valid       in   1   byte strobe / frame envelope; low aborts the datagram
//   din         in   8   byte stream, MSB-first fields
//   start       in   1   high on the cycle din carries UDP byte 0 (src_port[15:8])
//   ip_sa       in   32  IPv4 source from ip_decode (used only with UDP_CSUM_EN)
//   ip_da       in   32  IPv4 destination from ip_decode (used only with UDP_CSUM_EN)
//   src_port    out  16  captured source port
//   dst_port    out  16  captured destination port
//   udp_len     out  16  captured UDP length field (header + payload)
//   dout        out  8   payload byte
//   dout_valid  out  1   dout qualifier
//   dout_last   out  1   with dout_valid on the final payload byte
//   done        out  1   one-cycle pulse: datagram fully consumed, no error
//   err         out  1   sticky until next start, valid low or rst
// BEHAVIOUR
//   - Reset: one clock; reset is synchronous and active-high (rst), sampled on posedge clk.
//   - Reset values: all outputs 0; state IDLE.
//   - IDLE -> HDR when start && valid.
//     - Byte counter hdr_cnt=1 after the first byte is taken; the byte 0 taken from din that cycle.
//   - HDR: bytes 0-7 are src_port, dst_port, udp_len, csum, big-endian.
//     - Each field is registered the cycle after its 2nd byte.
//     - After byte 7: udp_len<8, (udp_len-8)>MAX_PAYLOAD, or dst_port!=LISTEN_PORT -> ERR.
//     - Otherwise udp_len==8 -> DONE; else -> PAYLOAD with rem=udp_len-8.
//   - PAYLOAD: each valid byte -> dout=din, dout_valid=1 exactly one cycle later.
//     - rem decrements per byte; the byte at rem==1 also sets dout_last, then -> DONE.
//     - Bytes after the last (Ethernet padding/FCS) are ignored until valid drops.
//   - DONE: done=1 for one cycle, then WAIT. ERR: err=1, then WAIT.
//     - WAIT holds until valid low -> IDLE.
//   - Latency: fixed 1 cycle din->dout; done/err asserted 1 cycle after the deciding byte.
//   - valid low in HDR/PAYLOAD -> err=1, dout_valid=0, -> IDLE; no done.
//     - valid low in IDLE/WAIT is silent.
//   - start while not IDLE: ignored (no restart mid-datagram).
//   - rst mid-datagram: immediate return to reset values; no partial last/done.
//   - dst_port captured even on filter miss (for debug); payload never emitted on err.
// CONFIGURATION
//   UDP_CSUM_EN defined:
//     - One's-complement 16-bit sum over the pseudo-header: ip_sa, ip_da, 16'h0011, udp_len.
//     - Sum also covers the UDP header and payload; an odd final byte is padded with 8'h00.
//     - End-around carry on every add.
//     - csum field 0 -> check skipped.
//     - Otherwise a final sum != 16'hFFFF gives err=1 instead of done, same cycle done would fire.
//     - Payload is still streamed; the consumer drops the frame on err.
//   UDP_CSUM_EN undefined: no checksum logic; csum field captured and discarded; ip_sa/ip_da unused.
// STRUCTURE
//   - Shared package net_pkg holds:
//     - UDP_HDR_LEN=8 and IPPROTO_UDP=8'd17.
//     - typedef enum udp_state_t {IDLE,HDR,PAYLOAD,DONE,ERR,WAIT}.
//     - function ones_add16(a,b) with end-around carry.
//   - Sub-module udp_csum_acc (clk, rst, clr, en, word[15:0], sum[15:0]).
//     - Instantiated only under UDP_CSUM_EN.
//     - Pairs bytes into words internally in udp_decode.
// TESTING
//   - Hdr 1F90 1388 000C xxxx + payload DE AD BE EF:
//     - src_port=8080, dst_port=5000, udp_len=12.
//     - dout DE,AD,BE,EF on consecutive cycles, last on EF, done 1 cycle after EF.
//   - dst_port 1389 (5001), len 000C -> err=1 after byte 7; dout_valid never high.
//   - udp_len 0008 -> done 1 cycle after byte 7, no dout_valid.
//   - udp_len 0005 -> err.
//   - valid dropped after 2nd payload byte of a 12-byte datagram:
//     - err=1, no dout_last, no done.
//     - Next start parses cleanly.
//   - Trailing padding: 4-byte payload followed by 6 pad bytes -> exactly 4 dout_valid, one done.
//   - UDP_CSUM_EN, ip_sa=C0A80001, ip_da=C0A80002, len 000A, payload 41 42:
//     - Correct csum -> done.
//     - csum flipped by 1 -> err.
//     - csum 0000 -> done.

Source files
------------

// File: rtl/net_pkg.sv
// net_pkg: shared RX-path constants, UDP parser states and
// one's-complement helper.
package net_pkg;

  localparam int         UDP_HDR_LEN = 8;
  localparam logic [7:0] IPPROTO_UDP = 8'd17;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PAYLOAD,
    DONE,
    ERR,
    WAIT
  } udp_state_t;

  function automatic logic [15:0] ones_add16(
    input logic [15:0] a,
    input logic [15:0] b
  );
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

endpackage

// File: rtl/udp_csum_acc.sv
// udp_csum_acc: 16-bit one's-complement accumulator.
// clr restarts the sum, loading word when en is also high.
module udp_csum_acc
  import net_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [15:0] word,
  output logic [15:0] sum
);

  logic [15:0] sum_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= 16'd0;
    end else if (clr) begin
      sum_q <= en ? word : 16'd0;
    end else if (en) begin
      sum_q <= ones_add16(sum_q, word);
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/udp_decode.sv
// udp_decode: byte-serial UDP header parser, port filter and payload streamer.
// Define UDP_CSUM_EN to verify the UDP checksum with the IPv4 pseudo-header.
module udp_decode
  import net_pkg::*;
#(
  parameter logic [15:0] LISTEN_PORT = 16'd5000,
  parameter logic [15:0] MAX_PAYLOAD = 16'd1472
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [7:0]  din,
  input  logic        start,
  input  logic [31:0] ip_sa,
  input  logic [31:0] ip_da,
  output logic [15:0] src_port,
  output logic [15:0] dst_port,
  output logic [15:0] udp_len,
  output logic [7:0]  dout,
  output logic        dout_valid,
  output logic        dout_last,
  output logic        done,
  output logic        err
);

  localparam logic [15:0] HDR_LEN16 = 16'(UDP_HDR_LEN);

  udp_state_t  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  hi_q, hi_d;
  logic [15:0] src_q, src_d;
  logic [15:0] dst_q, dst_d;
  logic [15:0] len_q, len_d;
  logic [15:0] rem_q, rem_d;
  logic [7:0]  dout_q, dout_d;
  logic        dv_q, dv_d;
  logic        last_q, last_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        hdr_bad;
  logic        csum_fail;

`ifdef UDP_CSUM_EN
  logic [15:0] csum_q, csum_d;
  logic        podd_q, podd_d;
  logic        acc_clr, acc_en;
  logic [15:0] acc_word, acc_sum, fin_sum;
  logic        csum_zero;

  udp_csum_acc u_acc (
    .clk  (clk),
    .rst  (rst),
    .clr  (acc_clr),
    .en   (acc_en),
    .word (acc_word),
    .sum  (acc_sum)
  );

  // Odd header bytes complete a UDP word; even ones slot in the pseudo-header.
  always_comb begin
    acc_clr  = 1'b0;
    acc_en   = 1'b0;
    acc_word = 16'd0;
    podd_d   = podd_q;
    csum_d   = csum_q;
    unique case (state_q)
      IDLE: begin
        if (valid && start) begin
          acc_clr  = 1'b1;
          acc_en   = 1'b1;
          acc_word = ip_sa[31:16];
        end
      end
      HDR: begin
        podd_d = 1'b0;
        if (valid) begin
          acc_en = 1'b1;
          if (cnt_q[0]) begin
            acc_word = {hi_q, din};
          end else begin
            case (cnt_q[2:1])
              2'd1:    acc_word = ip_sa[15:0];
              2'd2:    acc_word = ip_da[31:16];
              2'd3:    acc_word = ip_da[15:0];
              default: acc_word = 16'd0;
            endcase
          end
          if (cnt_q == 3'd7) begin
            csum_d = {hi_q, din};
          end
        end
      end
      PAYLOAD: begin
        if (valid) begin
          podd_d = ~podd_q;
          if (podd_q) begin
            acc_en   = 1'b1;
            acc_word = {hi_q, din};
          end else if (rem_q == 16'd1) begin
            acc_en   = 1'b1;
            acc_word = {din, 8'h00};
          end
        end
      end
      default: ;
    endcase
  end

  assign fin_sum = ones_add16(
                     ones_add16(ones_add16(acc_sum, acc_word),
                                {8'h00, IPPROTO_UDP}),
                     len_q);
  assign csum_zero = (state_q == HDR) ? ({hi_q, din} == 16'd0)
                                      : (csum_q == 16'd0);
  assign csum_fail = !csum_zero && (fin_sum != 16'hFFFF);

  always_ff @(posedge clk) begin
    if (rst) begin
      csum_q <= 16'd0;
      podd_q <= 1'b0;
    end else begin
      csum_q <= csum_d;
      podd_q <= podd_d;
    end
  end
`else
  logic unused_ip;
  assign unused_ip = ^{ip_sa, ip_da};
  assign csum_fail = 1'b0;
`endif

  assign hdr_bad = (len_q < HDR_LEN16)
                || ((len_q - HDR_LEN16) > MAX_PAYLOAD)
                || (dst_q != LISTEN_PORT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    rem_d   = rem_q;
    dout_d  = dout_q;
    dv_d    = 1'b0;
    last_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (valid && start) begin
          hi_d    = din;
          cnt_d   = 3'd1;
          err_d   = 1'b0;
          state_d = HDR;
        end
      end
      HDR: begin
        if (!valid) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          hi_d  = din;
          cnt_d = cnt_q + 3'd1;
          case (cnt_q)
            3'd1:    src_d = {hi_q, din};
            3'd3:    dst_d = {hi_q, din};
            3'd5:    len_d = {hi_q, din};
            default: ;
          endcase
          if (cnt_q == 3'd7) begin
            if (hdr_bad || (len_q == HDR_LEN16 && csum_fail)) begin
              err_d   = 1'b1;
              state_d = ERR;
            end else if (len_q == HDR_LEN16) begin
              done_d  = 1'b1;
              state_d = DONE;
            end else begin
              rem_d   = len_q - HDR_LEN16;
              state_d = PAYLOAD;
            end
          end
        end
      end
      PAYLOAD: begin
        if (!valid) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          hi_d   = din;
          dout_d = din;
          dv_d   = 1'b1;
          rem_d  = rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            last_d = 1'b1;
            if (csum_fail) begin
              err_d   = 1'b1;
              state_d = ERR;
            end else begin
              done_d  = 1'b1;
              state_d = DONE;
            end
          end
        end
      end
      DONE, ERR, WAIT: begin
        // Trailing pad/FCS bytes are swallowed until the frame envelope drops.
        if (!valid) begin
          err_d   = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      hi_q    <= 8'd0;
      src_q   <= 16'd0;
      dst_q   <= 16'd0;
      len_q   <= 16'd0;
      rem_q   <= 16'd0;
      dout_q  <= 8'd0;
      dv_q    <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      last_q  <= last_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign src_port   = src_q;
  assign dst_port   = dst_q;
  assign udp_len    = len_q;
  assign dout       = dout_q;
  assign dout_valid = dv_q;
  assign dout_last  = last_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_udp_decode.sv
// tb_udp_decode: directed and random datagrams against a frame-level model
// of the UDP parser (define UDP_CSUM_EN to model the checksum too).
module tb_udp_decode;

  localparam logic [15:0] LPORT = 16'd5000;
  localparam int          MAXP  = 1472;

  logic        clk = 1'b0;
  logic        rst, valid, start;
  logic [7:0]  din;
  logic [31:0] ip_sa, ip_da;
  logic [15:0] src_port, dst_port, udp_len;
  logic [7:0]  dout;
  logic        dout_valid, dout_last, done, err;

  udp_decode dut (
    .clk        (clk),
    .rst        (rst),
    .valid      (valid),
    .din        (din),
    .start      (start),
    .ip_sa      (ip_sa),
    .ip_da      (ip_da),
    .src_port   (src_port),
    .dst_port   (dst_port),
    .udp_len    (udp_len),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_last  (dout_last),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] mq[$];
  int         mc[$];
  bit         ml[$];
  int         dq[$];
  int         eq[$];
  int         stray = 0;
  logic       err_prev = 1'b0;

  always @(negedge clk) begin
    if (dout_valid) begin
      mq.push_back(dout);
      mc.push_back(cyc);
      ml.push_back(dout_last);
    end
    if (dout_last && !dout_valid) stray <= stray + 1;
    if (done) dq.push_back(cyc);
    if (err && !err_prev) eq.push_back(cyc);
    err_prev <= err;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

`ifdef UDP_CSUM_EN
  function automatic logic [15:0] csum_fold(
    input logic [15:0] src, dst, len, ck,
    input logic [7:0] pl[$], input int plen);
    logic [31:0] acc;
    acc = 32'(ip_sa[31:16]) + 32'(ip_sa[15:0]) + 32'(ip_da[31:16])
        + 32'(ip_da[15:0]) + 32'd17 + 32'(len)
        + 32'(src) + 32'(dst) + 32'(len) + 32'(ck);
    for (int i = 0; i < plen; i += 2)
      acc += {16'd0, pl[i], (i + 1 < plen) ? pl[i+1] : 8'h00};
    while (acc[31:16] != 16'd0) acc = 32'(acc[15:0]) + 32'(acc[31:16]);
    return acc[15:0];
  endfunction
`endif

  // Drives one datagram (optionally cut short) and checks the outcome.
  task automatic run_frame(input logic [15:0] src, dst, len, ck,
                           input logic [7:0] pl[$], input int pad,
                           input int cut);
    logic [7:0] s[$];
    int dc[$];
    int total, ce, m0, d0, e0, plen, nexp, na, bad_n, ecyc;
    bit bad, full, csum_ok, dexp;
    s = {src[15:8], src[7:0], dst[15:8], dst[7:0],
         len[15:8], len[7:0], ck[15:8], ck[7:0]};
    foreach (pl[i]) s.push_back(pl[i]);
    repeat (pad) s.push_back(8'($urandom));
    total = s.size();
    ce = (cut > 0 && cut < total) ? cut : total;
    m0 = mq.size();
    d0 = dq.size();
    e0 = eq.size();
    for (int i = 0; i < ce; i++) begin
      @(negedge clk);
      valid = 1'b1;
      din   = s[i];
      start = (i == 0);
      dc.push_back(cyc);
    end
    @(negedge clk);
    valid = 1'b0;
    start = 1'b0;
    din   = 8'h00;
    repeat (4) @(negedge clk);
    #1;

    bad  = (len < 16'd8) || (int'(len) - 8 > MAXP) || (dst != LPORT);
    plen = (len >= 16'd8) ? int'(len) - 8 : 0;
    nexp = (!bad && ce >= 8) ? ((plen < ce - 8) ? plen : ce - 8) : 0;
    full = !bad && ce >= 8 + plen;
    csum_ok = 1'b1;
`ifdef UDP_CSUM_EN
    if (full && ck != 16'd0)
      csum_ok = (csum_fold(src, dst, len, ck, pl, plen) == 16'hFFFF);
`endif
    dexp = full && csum_ok;
    if (ce < 8)         ecyc = dc[ce-1] + 2;
    else if (bad)       ecyc = dc[7] + 1;
    else if (!full)     ecyc = dc[ce-1] + 2;
    else                ecyc = dc[7+plen] + 1;

    na = mq.size() - m0;
    check("dout_count", 32'(na), 32'(nexp));
    bad_n = 0;
    for (int i = 0; i < na && i < nexp; i++) begin
      if (mq[m0+i] !== pl[i]) bad_n++;
      if (mc[m0+i] != dc[8+i] + 1) bad_n++;
      if (ml[m0+i] != (full && i == nexp - 1)) bad_n++;
    end
    check("dout_bytes", 32'(bad_n), 32'd0);
    check("done_count", 32'(dq.size() - d0), 32'(dexp));
    if (dexp) check("done_cycle", 32'(dq[d0]), 32'(dc[7+plen] + 1));
    check("err_count", 32'(eq.size() - e0), 32'(!dexp));
    if (!dexp && eq.size() > e0) check("err_cycle", 32'(eq[e0]), 32'(ecyc));
    if (ce >= 6) begin
      check("src_port", 32'(src_port), 32'(src));
      check("dst_port", 32'(dst_port), 32'(dst));
      check("udp_len", 32'(udp_len), 32'(len));
    end
  endtask

  initial begin
    logic [7:0]  pl[$];
    logic [7:0]  s[$];
    logic [15:0] dst, len, ck;
    int          d0, m0, lasts, plg, cut, r;

    rst   = 1'b1;
    valid = 1'b0;
    start = 1'b0;
    din   = 8'h00;
    ip_sa = 32'hC0A80001;
    ip_da = 32'hC0A80002;
    repeat (2) @(negedge clk);
    check("rst_ports", {src_port, dst_port}, 32'd0);
    check("rst_len_dout", {8'd0, udp_len, dout}, 32'd0);
    check("rst_flags", {28'd0, dout_valid, dout_last, done, err}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    pl = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_frame(16'h1F90, 16'h1388, 16'h000C, 16'h0000, pl, 0, 0);
    run_frame(16'h1F90, 16'h1389, 16'h000C, 16'h0000, pl, 0, 0);
    run_frame(16'h1234, 16'h1388, 16'h000C, 16'h0000, pl, 0, 10);
    run_frame(16'h1F90, 16'h1388, 16'h000C, 16'h0000, pl, 0, 0);
    run_frame(16'h1F90, 16'h1388, 16'h000C, 16'h0000, pl, 6, 0);
    pl = {};
    run_frame(16'h0101, 16'h1388, 16'h0008, 16'h0000, pl, 0, 0);
    run_frame(16'h0202, 16'h1388, 16'h0005, 16'h0000, pl, 0, 0);
    check("no_stray_last", 32'(stray), 32'd0);

    // Reset in the middle of a payload: no last/done may escape.
    s = {8'h1F, 8'h90, 8'h13, 8'h88, 8'h00, 8'h0C, 8'h00, 8'h00,
         8'h11, 8'h22};
    d0 = dq.size();
    m0 = mq.size();
    foreach (s[i]) begin
      @(negedge clk);
      valid = 1'b1;
      din   = s[i];
      start = (i == 0);
    end
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("midrst_ports", {src_port, dst_port}, 32'd0);
    check("midrst_flags", {28'd0, dout_valid, dout_last, done, err}, 32'd0);
    rst   = 1'b0;
    valid = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    lasts = 0;
    for (int i = m0; i < ml.size(); i++) if (ml[i]) lasts++;
    check("midrst_no_last", 32'(lasts), 32'd0);
    check("midrst_no_done", 32'(dq.size() - d0), 32'd0);

`ifdef UDP_CSUM_EN
    pl = {8'h41, 8'h42};
    ck = ~csum_fold(16'h1F90, 16'h1388, 16'h000A, 16'h0000, pl, 2);
    run_frame(16'h1F90, 16'h1388, 16'h000A, ck, pl, 0, 0);
    run_frame(16'h1F90, 16'h1388, 16'h000A, ck ^ 16'h0001, pl, 0, 0);
    run_frame(16'h1F90, 16'h1388, 16'h000A, 16'h0000, pl, 0, 0);
`endif

    for (int f = 0; f < 40; f++) begin
      r   = $urandom_range(0, 9);
      dst = (r < 7) ? LPORT : 16'($urandom_range(0, 65535));
      r   = $urandom_range(0, 9);
      if (r == 0)      len = 16'($urandom_range(0, 7));
      else if (r == 1) len = 16'($urandom_range(1481, 3000));
      else             len = 16'(8 + $urandom_range(0, 24));
      plg = (len >= 16'd8 && len <= 16'd1480) ? int'(len) - 8 : 4;
      pl = {};
      repeat (plg) pl.push_back(8'($urandom));
      cut = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 9 + plg) : 0;
      ck  = 16'($urandom);
      run_frame(16'($urandom), dst, len, ck, pl,
                $urandom_range(0, 6), cut);
    end
    check("final_stray_last", 32'(stray), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
